// File: rtl/program_counter_pkg.sv
// Shared types and defaults for the program counter slice.
// Build option PROGRAM_COUNTER_STACK_EN enables the return-address stack.
package pc_pkg;

  localparam int ADDR_W_DEFAULT = 16;
  localparam logic [ADDR_W_DEFAULT-1:0] RESET_VECTOR_DEFAULT = '0;

  typedef logic [ADDR_W_DEFAULT-1:0] addr_t;

  // Listed in ascending priority; the top-level encoder emits exactly one.
  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_LOAD = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } pc_op_e;

endpackage

// File: rtl/program_counter_if.sv
// Control-unit to program-counter bus; call/ret/stk_* exist only when
// PROGRAM_COUNTER_STACK_EN is defined.
interface program_counter_if import pc_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEFAULT
) ();

  logic              increment;
  logic              load;
  logic [ADDR_W-1:0] d_bus;
  logic [ADDR_W-1:0] i_addr;
`ifdef PROGRAM_COUNTER_STACK_EN
  logic              call;
  logic              ret;
  logic              stk_ovf;
  logic              stk_unf;
`endif

  modport master (
    output increment, load, d_bus,
`ifdef PROGRAM_COUNTER_STACK_EN
    output call, ret,
    input  stk_ovf, stk_unf,
`endif
    input  i_addr
  );

  modport slave (
    input  increment, load, d_bus,
`ifdef PROGRAM_COUNTER_STACK_EN
    input  call, ret,
    output stk_ovf, stk_unf,
`endif
    output i_addr
  );

endinterface

// File: rtl/program_counter_return_stack.sv
// Register-file LIFO of return addresses (built only with PROGRAM_COUNTER_STACK_EN).
// Push into a full stack and pop from an empty stack are ignored.
module pc_return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   r_sp;
  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_sp == (PTR_W+1)'(DEPTH));
  assign empty     = (r_sp == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty && !push;
  // Low bits wrap to DEPTH-1 when the stack is full, which is the top entry.
  assign w_top_idx = r_sp[PTR_W-1:0] - PTR_W'(1);
  assign dout      = r_mem[w_top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + (PTR_W+1)'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_do_push) begin
      r_mem[r_sp[PTR_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/program_counter.sv
// Instruction-address register: hold / increment / load, plus call/ret with a
// return stack when PROGRAM_COUNTER_STACK_EN is defined. 1-cycle latency.
module program_counter import pc_pkg::*; #(
  parameter int                ADDR_W       = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT),
  parameter int                INC_STEP     = 1,
  parameter int                STACK_DEPTH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  program_counter_if.slave pc
);

  if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_stack_depth
    $error("STACK_DEPTH must be a power of two and at least 2");
  end

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] w_inc_addr;
  pc_op_e            w_op;

  assign w_inc_addr = r_addr + ADDR_W'(INC_STEP);
  assign pc.i_addr  = r_addr;

`ifdef PROGRAM_COUNTER_STACK_EN
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] w_top;
  logic              r_ovf;
  logic              r_unf;

  always_comb begin
    w_op = OP_HOLD;
    if (pc.ret)            w_op = OP_RET;
    else if (pc.call)      w_op = OP_CALL;
    else if (pc.load)      w_op = OP_LOAD;
    else if (pc.increment) w_op = OP_INC;
  end

  // The return address is the fall-through of the call site.
  assign w_push = (w_op == OP_CALL) && !w_full;
  assign w_pop  = (w_op == OP_RET) && !w_empty;

  pc_return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_inc_addr),
    .dout  (w_top),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_op == OP_CALL && w_full) r_ovf <= 1'b1;
      if (w_op == OP_RET && w_empty) r_unf <= 1'b1;
    end
  end

  assign pc.stk_ovf = r_ovf;
  assign pc.stk_unf = r_unf;
`else
  always_comb begin
    w_op = OP_HOLD;
    if (pc.load)           w_op = OP_LOAD;
    else if (pc.increment) w_op = OP_INC;
  end
`endif

  always_comb begin
    w_next_addr = r_addr;
    case (w_op)
      OP_INC:  w_next_addr = w_inc_addr;
      OP_LOAD: w_next_addr = pc.d_bus;
      OP_CALL: w_next_addr = pc.d_bus;
`ifdef PROGRAM_COUNTER_STACK_EN
      OP_RET:  w_next_addr = w_empty ? r_addr : w_top;
`endif
      default: w_next_addr = r_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_addr <= RESET_VECTOR;
    else     r_addr <= w_next_addr;
  end

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter with a reference model feeding a scoreboard;
// stack steps are compiled in only with PROGRAM_COUNTER_STACK_EN.
module tb_program_counter;
  import pc_pkg::*;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [15:0] addr;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic        clk;
  logic        rst;
  exp_t        sb[$];
  logic [15:0] m_addr;
  logic [15:0] m_stk[$];
  logic        m_ovf;
  logic        m_unf;
  int          n_pass;
  int          n_total;

  program_counter_if #(.ADDR_W(16)) bus ();

  program_counter #(
    .ADDR_W       (16),
    .RESET_VECTOR (16'h0000),
    .INC_STEP     (1),
    .STACK_DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pc  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input string tag, input logic s_rst, input logic s_ret,
                      input logic s_call, input logic s_load, input logic s_inc,
                      input logic [15:0] d);
    exp_t e;
    rst           = s_rst;
    bus.load      = s_load;
    bus.increment = s_inc;
    bus.d_bus     = d;
`ifdef PROGRAM_COUNTER_STACK_EN
    bus.call      = s_call;
    bus.ret       = s_ret;
`endif
    if (s_rst) begin
      m_addr = 16'h0000;
      m_stk.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
`ifdef PROGRAM_COUNTER_STACK_EN
    end else if (s_ret) begin
      if (m_stk.size() > 0) m_addr = m_stk.pop_back();
      else                  m_unf  = 1'b1;
    end else if (s_call) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(m_addr + 16'd1);
      else                      m_ovf = 1'b1;
      m_addr = d;
`endif
    end else if (s_load) begin
      m_addr = d;
    end else if (s_inc) begin
      m_addr = m_addr + 16'd1;
    end
    e.addr = m_addr;
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_total++;
    assert (bus.i_addr === e.addr) n_pass++;
    else $error("FAIL %s i_addr got=%h exp=%h", tag, bus.i_addr, e.addr);
`ifdef PROGRAM_COUNTER_STACK_EN
    n_total++;
    assert (bus.stk_ovf === e.ovf) n_pass++;
    else $error("FAIL %s stk_ovf got=%b exp=%b", tag, bus.stk_ovf, e.ovf);
    n_total++;
    assert (bus.stk_unf === e.unf) n_pass++;
    else $error("FAIL %s stk_unf got=%b exp=%b", tag, bus.stk_unf, e.unf);
`endif
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    m_addr  = 'x;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    rst           = 1'b0;
    bus.load      = 1'b0;
    bus.increment = 1'b0;
    bus.d_bus     = '0;
`ifdef PROGRAM_COUNTER_STACK_EN
    bus.call      = 1'b0;
    bus.ret       = 1'b0;
`endif
    @(negedge clk);

    //   tag           rst  ret  call load inc  d_bus
    step("reset",      1, 0, 0, 0, 0, 16'h0000);
    step("hold1",      0, 0, 0, 0, 0, 16'hAAAA);
    step("hold2",      0, 0, 0, 0, 0, 16'h5555);
    step("hold3",      0, 0, 0, 0, 0, 16'h1111);
    step("load_zero",  0, 0, 0, 1, 0, 16'h0000);
    step("inc_1",      0, 0, 0, 0, 1, 16'h0000);
    step("inc_2",      0, 0, 0, 0, 1, 16'hBEEF);
    step("load_wins",  0, 0, 0, 1, 1, 16'h1234);
    step("hold_1234",  0, 0, 0, 0, 0, 16'h0000);
    step("load_ffff",  0, 0, 0, 1, 0, 16'hFFFF);
    step("wrap",       0, 0, 0, 0, 1, 16'h0000);
    step("load_0040",  0, 0, 0, 1, 0, 16'h0040);
    step("rst_beats",  1, 0, 0, 1, 1, 16'h5555);
    step("inc_post",   0, 0, 0, 0, 1, 16'h0000);

`ifdef PROGRAM_COUNTER_STACK_EN
    step("load_0010",  0, 0, 0, 1, 0, 16'h0010);
    step("call_0100",  0, 0, 1, 1, 1, 16'h0100);
    step("ret_0011",   0, 1, 0, 0, 0, 16'h0000);
    step("ret_empty",  0, 1, 0, 0, 1, 16'h7777);
    for (int i = 0; i < DEPTH + 1; i++) begin
      step($sformatf("call_%0d", i), 0, 0, 1, 0, 0, 16'h0200 + 16'(i * 16));
    end
    step("ret_full",   0, 1, 0, 0, 0, 16'h0000);
    step("ret_wins",   0, 1, 1, 1, 1, 16'h9999);
    step("rst_flags",  1, 0, 0, 0, 0, 16'h0000);
`endif

    n_total++;
    assert (sb.size() == 0) n_pass++;
    else $error("FAIL scoreboard_drain got=%0d exp=0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
